// File: rtl/zlib_wrap_if.sv
// Handshake bundle around zlib_wrap: payload words in, Adler-32 result in, zlib stream words out.
interface zlib_wrap_if;
   logic        start_i;
   logic        val_i;
   logic        rdy_o;
   logic [31:0] dat_i;
   logic        lst_i;
   logic [2:0]  nbyt_i;
   logic        adl_val_i;
   logic [31:0] adl_dat_i;
   logic        val_o;
   logic        rdy_i;
   logic [31:0] dat_o;
   logic        lst_o;
   logic [2:0]  nbyt_o;
   logic        done_o;

   modport master (
      output start_i, val_i, dat_i, lst_i, nbyt_i, adl_val_i, adl_dat_i, rdy_i,
      input  rdy_o, val_o, dat_o, lst_o, nbyt_o, done_o
   );

   modport slave (
      input  start_i, val_i, dat_i, lst_i, nbyt_i, adl_val_i, adl_dat_i, rdy_i,
      output rdy_o, val_o, dat_o, lst_o, nbyt_o, done_o
   );
endinterface

// File: rtl/zlib_wrap.sv
// zlib framer: prepends CMF/FLG, passes the deflate payload through a 64-bit byte
// accumulator and appends the big-endian Adler-32 trailer.
module zlib_wrap #(
   parameter logic [7:0] HDR_CMF = 8'h78,
   parameter logic [7:0] HDR_FLG = 8'h01
) (
   input logic        clk,
   input logic        rst,
   zlib_wrap_if.slave bus
);
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 2 * DW;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DATA     = 2'd1;
   localparam logic [1:0] S_WAIT_ADL = 2'd2;
   localparam logic [1:0] S_FLUSH    = 2'd3;

   logic [1:0]    state_r, state_nx;
   logic [AW-1:0] acc_r, acc_nx;
   logic [2:0]    cnt_r, cnt_nx;
   logic          adl_got_r, adl_got_nx;
   logic [DW-1:0] adl_buf_r, adl_buf_nx;

   logic          rdy_r, rdy_nx;
   logic          val_r, val_nx;
   logic [DW-1:0] dat_r, dat_nx;
   logic          lst_r, lst_nx;
   logic [2:0]    nbyt_r, nbyt_nx;
   logic          done_r, done_nx;

   logic          acc_hs_c;
   logic          emit_hs_c;
   logic [2:0]    nb_c;
   logic [5:0]    keep_sh_c;
   logic [DW-1:0] keep_c;
   logic [AW-1:0] acc_sh_c;
   logic [2:0]    cnt_sh_c;

   assign acc_hs_c  = bus.val_i & rdy_r;
   assign emit_hs_c = val_r & bus.rdy_i;

   // Byte count of the incoming word and a mask that clears its unused trailing lanes
   always_comb begin
      nb_c = 3'd4;
      if (bus.lst_i && (bus.nbyt_i != 3'd0) && (bus.nbyt_i < 3'd4)) nb_c = bus.nbyt_i;
      keep_sh_c = {3'(3'd4 - nb_c), 3'b000};
      keep_c    = {DW{1'b1}} << keep_sh_c;
   end

   // Accumulator after one output word leaves
   always_comb begin
      acc_sh_c = {acc_r[DW-1:0], {DW{1'b0}}};
      cnt_sh_c = (cnt_r > 3'd4) ? 3'(cnt_r - 3'd4) : 3'd0;
   end

   always_comb begin
      state_nx   = state_r;
      acc_nx     = acc_r;
      cnt_nx     = cnt_r;
      adl_got_nx = adl_got_r;
      adl_buf_nx = adl_buf_r;
      done_nx    = 1'b0;
      rdy_nx     = 1'b0;
      val_nx     = 1'b0;
      dat_nx     = '0;
      lst_nx     = 1'b0;
      nbyt_nx    = 3'd0;

      case (state_r)
         S_IDLE: begin
            if (bus.start_i) begin
               state_nx   = S_DATA;
               acc_nx     = {HDR_CMF, HDR_FLG, {(AW-16){1'b0}}};
               cnt_nx     = 3'd2;
               adl_got_nx = 1'b0;
            end
         end
         S_DATA: begin
            if (acc_hs_c) begin
               acc_nx = acc_r | ({bus.dat_i & keep_c, {DW{1'b0}}} >> {cnt_r, 3'b000});
               cnt_nx = 3'(cnt_r + nb_c);
               if (bus.lst_i) state_nx = S_WAIT_ADL;
            end else if (emit_hs_c) begin
               acc_nx = acc_sh_c;
               cnt_nx = cnt_sh_c;
            end
         end
         S_WAIT_ADL: begin
            if (emit_hs_c) begin
               acc_nx = acc_sh_c;
               cnt_nx = cnt_sh_c;
            end else if (adl_got_r && (cnt_r < 3'd4)) begin
               acc_nx   = acc_r | ({adl_buf_r, {DW{1'b0}}} >> {cnt_r, 3'b000});
               cnt_nx   = 3'(cnt_r + 3'd4);
               state_nx = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (emit_hs_c) begin
               acc_nx = acc_sh_c;
               cnt_nx = cnt_sh_c;
               if (lst_r) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Checksum may land any time after start; a later pulse replaces an earlier one
      if ((state_r != S_IDLE) && bus.adl_val_i) begin
         adl_buf_nx = bus.adl_dat_i;
         adl_got_nx = 1'b1;
      end

      rdy_nx = (state_nx == S_DATA) && (cnt_nx < 3'd4);
      if ((state_nx == S_DATA) || (state_nx == S_WAIT_ADL)) val_nx = (cnt_nx >= 3'd4);
      else if (state_nx == S_FLUSH)                           val_nx = (cnt_nx != 3'd0);
      lst_nx = (state_nx == S_FLUSH) && (cnt_nx <= 3'd4);
      if (val_nx) nbyt_nx = (cnt_nx > 3'd4) ? 3'd4 : cnt_nx;
      for (int unsigned i = 0; i < 4; i++) begin
         if (3'(i) < cnt_nx) dat_nx[DW-1-8*i -: 8] = acc_nx[AW-1-8*i -: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         acc_r     <= '0;
         cnt_r     <= 3'd0;
         adl_got_r <= 1'b0;
         adl_buf_r <= '0;
         rdy_r     <= 1'b0;
         val_r     <= 1'b0;
         dat_r     <= '0;
         lst_r     <= 1'b0;
         nbyt_r    <= 3'd0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nx;
         acc_r     <= acc_nx;
         cnt_r     <= cnt_nx;
         adl_got_r <= adl_got_nx;
         adl_buf_r <= adl_buf_nx;
         rdy_r     <= rdy_nx;
         val_r     <= val_nx;
         dat_r     <= dat_nx;
         lst_r     <= lst_nx;
         nbyt_r    <= nbyt_nx;
         done_r    <= done_nx;
      end
   end

   assign bus.rdy_o  = rdy_r;
   assign bus.val_o  = val_r;
   assign bus.dat_o  = dat_r;
   assign bus.lst_o  = lst_r;
   assign bus.nbyt_o = nbyt_r;
   assign bus.done_o = done_r;
endmodule

// File: tb/tb_zlib_wrap.sv
// Bench for zlib_wrap: directed vector table, back-pressure and reset sequences, and
// random payloads checked against a software zlib framing model through a scoreboard.
module tb_zlib_wrap;
   typedef struct packed {
      logic [31:0] dat;
      logic [2:0]  nb;
      logic        lst;
   } exp_t;

   typedef struct {
      logic [31:0] w [2];
      int          nw;
      logic [2:0]  nb_last;
      logic [31:0] adl;
      int          adl_mode;
      logic [31:0] ew [4];
      int          ne;
      logic [2:0]  enb_last;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   zlib_wrap_if bus();

   zlib_wrap #(.HDR_CMF(8'h78), .HDR_FLG(8'h01)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          total    = 0;
   int          bad      = 0;
   int          done_cnt = 0;
   exp_t        sb [$];
   logic [31:0] pw [$];
   logic [7:0]  pb [$];
   logic        hs;
   logic        stall_prev;
   logic [36:0] held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output-side observer: scoreboard pop, hold-under-stall and ready/valid exclusivity
   task automatic monitor();
      exp_t        e;
      logic [36:0] cur;
      cur = {bus.val_o, bus.dat_o, bus.nbyt_o, bus.lst_o};
      if (rst) begin
         stall_prev = 1'b0;
         return;
      end
      if (stall_prev) chk("hold_under_stall", 64'(cur), 64'(held));
      if (bus.val_o) chk("rdy_o_low_while_val_o", 64'(bus.rdy_o), 64'd0);
      if (bus.val_o && bus.rdy_i) begin
         chk("word_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_word{dat,nb,lst}", 64'({bus.dat_o, bus.nbyt_o, bus.lst_o}), 64'(e));
         end
      end
      if (bus.done_o) done_cnt++;
      stall_prev = bus.val_o && !bus.rdy_i;
      held       = cur;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      hs = bus.val_i && bus.rdy_o;
      @(posedge clk);
      #1;
   endtask

   // mode 0: Adler before any word; 1: bogus early then real mid-stream; 2: after last word.
   // bp 0: rdy_i always 1; 1: random; 2: five-cycle stall with back-to-back payload.
   task automatic drive(input logic [2:0] nb_last, input logic [31:0] adl, input int mode, input int bp);
      int d0;
      int widx = 0;
      int cyc  = 0;
      int post = 0;
      bit sent = 1'b0;
      int nw   = pw.size();
      d0 = done_cnt;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      while (done_cnt == d0 && cyc < 4000) begin
         if (widx < nw) begin
            if (bp == 2) bus.val_i = 1'b1;
            else if (!bus.val_i) bus.val_i = ($urandom_range(0, 3) != 0);
            bus.dat_i  = pw[widx];
            bus.lst_i  = (widx == nw - 1);
            bus.nbyt_i = bus.lst_i ? nb_last : 3'd4;
         end else begin
            bus.val_i = 1'b0;
         end
         bus.adl_val_i = 1'b0;
         case (mode)
            0: if (cyc == 0) begin
                  bus.val_i     = 1'b0;
                  bus.adl_val_i = 1'b1;
                  bus.adl_dat_i = adl;
               end
            1: if (cyc == 0) begin
                  bus.adl_val_i = 1'b1;
                  bus.adl_dat_i = 32'hDEAD_DEAD;
               end else if (!sent && widx >= nw / 2) begin
                  bus.adl_val_i = 1'b1;
                  bus.adl_dat_i = adl;
                  sent          = 1'b1;
               end
            default: if (widx == nw) begin
                  if (post == 3) begin
                     bus.adl_val_i = 1'b1;
                     bus.adl_dat_i = adl;
                  end
                  post++;
               end
         endcase
         case (bp)
            1:       bus.rdy_i = ($urandom_range(0, 2) != 0);
            2:       bus.rdy_i = !(cyc >= 3 && cyc < 8);
            default: bus.rdy_i = 1'b1;
         endcase
         tick();
         if (hs) begin
            widx++;
            bus.val_i = 1'b0;
         end
         cyc++;
      end
      chk("stream_timeout", 64'(cyc < 4000), 64'd1);
      bus.val_i     = 1'b0;
      bus.adl_val_i = 1'b0;
      bus.rdy_i     = 1'b1;
      tick();
      chk("all_words_out", 64'(sb.size()), 64'd0);
      chk("done_single_pulse", 64'(done_cnt - d0), 64'd1);
      sb.delete();
   endtask

   // Reference zlib framing of pb[] with a software Adler-32, then drive it
   task automatic model_stream(input int mode, input int bp);
      logic [31:0] a = 32'd1;
      logic [31:0] b = 32'd0;
      logic [31:0] adl;
      logic [31:0] w;
      logic [7:0]  full [$];
      logic [2:0]  nbl;
      int          n;
      foreach (pb[i]) begin
         a = (a + 32'(pb[i])) % 32'd65521;
         b = (b + a) % 32'd65521;
      end
      adl = {b[15:0], a[15:0]};
      full.push_back(8'h78);
      full.push_back(8'h01);
      foreach (pb[i]) full.push_back(pb[i]);
      for (int k = 0; k < 4; k++) full.push_back(adl[31-8*k -: 8]);
      sb.delete();
      for (int i = 0; i < full.size(); i += 4) begin
         n = (full.size() - i < 4) ? full.size() - i : 4;
         w = 32'd0;
         for (int k = 0; k < n; k++) w[31-8*k -: 8] = full[i+k];
         sb.push_back('{dat: w, nb: 3'(n), lst: (i + 4 >= full.size())});
      end
      pw.delete();
      for (int i = 0; i < pb.size(); i += 4) begin
         w = 32'hEEEE_EEEE;
         for (int k = 0; k < 4; k++) if (i + k < pb.size()) w[31-8*k -: 8] = pb[i+k];
         pw.push_back(w);
      end
      n   = pb.size() % 4;
      nbl = (n == 0) ? (($urandom_range(0, 1) != 0) ? 3'd0 : 3'd4) : 3'(n);
      drive(nbl, adl, mode, bp);
   endtask

   function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1, input int nw,
                               input logic [2:0] nb, input logic [31:0] adl, input int mode,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                               input logic [31:0] e3, input int ne, input logic [2:0] enb);
      vec_t v;
      v.w[0] = w0;  v.w[1] = w1;  v.nw = nw;  v.nb_last = nb;
      v.adl = adl;  v.adl_mode = mode;
      v.ew[0] = e0; v.ew[1] = e1; v.ew[2] = e2; v.ew[3] = e3;
      v.ne = ne;    v.enb_last = enb;
      return v;
   endfunction

   initial begin
      vec_t tv [6];
      int   d0;
      int   len;

      tv[0] = mk(32'hAABBCCDD, 32'h0, 1, 3'd4, 32'h11223344, 2,
                 32'h7801AABB, 32'hCCDD1122, 32'h33440000, 32'h0, 3, 3'd2);
      tv[1] = mk(32'hAABB0000, 32'h0, 1, 3'd2, 32'h11223344, 1,
                 32'h7801AABB, 32'h11223344, 32'h0, 32'h0, 2, 3'd4);
      tv[2] = mk(32'h01020304, 32'h05060708, 2, 3'd4, 32'h0E0F1011, 0,
                 32'h78010102, 32'h03040506, 32'h07080E0F, 32'h10110000, 4, 3'd2);
      tv[3] = mk(32'hDEADBEEF, 32'h0, 1, 3'd0, 32'hCAFEF00D, 1,
                 32'h7801DEAD, 32'hBEEFCAFE, 32'hF00D0000, 32'h0, 3, 3'd2);
      tv[4] = mk(32'h5A000000, 32'h0, 1, 3'd1, 32'h01020304, 0,
                 32'h78015A01, 32'h02030400, 32'h0, 32'h0, 2, 3'd3);
      tv[5] = mk(32'h123456FF, 32'h0, 1, 3'd3, 32'hA1B2C3D4, 2,
                 32'h78011234, 32'h56A1B2C3, 32'hD4000000, 32'h0, 3, 3'd1);

      bus.start_i   = 1'b0;
      bus.val_i     = 1'b0;
      bus.dat_i     = 32'd0;
      bus.lst_i     = 1'b0;
      bus.nbyt_i    = 3'd0;
      bus.adl_val_i = 1'b0;
      bus.adl_dat_i = 32'd0;
      bus.rdy_i     = 1'b1;
      stall_prev    = 1'b0;
      held          = '0;
      hs            = 1'b0;
      rst           = 1'b1;
      tick();
      tick();
      chk("reset_rdy_o",  64'(bus.rdy_o),  64'd0);
      chk("reset_val_o",  64'(bus.val_o),  64'd0);
      chk("reset_lst_o",  64'(bus.lst_o),  64'd0);
      chk("reset_nbyt_o", 64'(bus.nbyt_o), 64'd0);
      chk("reset_done_o", 64'(bus.done_o), 64'd0);
      chk("reset_dat_o",  64'(bus.dat_o),  64'd0);
      rst = 1'b0;
      tick();

      // Directed vectors
      for (int t = 0; t < 6; t++) begin
         sb.delete();
         pw.delete();
         for (int j = 0; j < tv[t].nw; j++) pw.push_back(tv[t].w[j]);
         for (int j = 0; j < tv[t].ne; j++)
            sb.push_back('{dat: tv[t].ew[j],
                           nb:  (j == tv[t].ne - 1) ? tv[t].enb_last : 3'd4,
                           lst: (j == tv[t].ne - 1)});
         drive(tv[t].nb_last, tv[t].adl, tv[t].adl_mode, 0);
      end

      // Downstream stall of five cycles with a full accumulator
      pb.delete();
      for (int i = 1; i <= 8; i++) pb.push_back(8'(i));
      model_stream(2, 2);

      // Reset while waiting for the checksum abandons the stream without done_o
      sb.delete();
      sb.push_back('{dat: 32'h7801AABB, nb: 3'd4, lst: 1'b0});
      d0 = done_cnt;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      bus.dat_i   = 32'hAABBCCDD;
      bus.lst_i   = 1'b1;
      bus.nbyt_i  = 3'd4;
      bus.val_i   = 1'b1;
      repeat (8) tick();
      bus.val_i = 1'b0;
      chk("pre_reset_words", 64'(sb.size()), 64'd0);
      rst = 1'b1;
      tick();
      chk("midrst_val_o",  64'(bus.val_o),  64'd0);
      chk("midrst_rdy_o",  64'(bus.rdy_o),  64'd0);
      chk("midrst_done_o", 64'(bus.done_o), 64'd0);
      rst = 1'b0;
      tick();
      tick();
      chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      pb.delete();
      pb.push_back(8'hAA); pb.push_back(8'hBB); pb.push_back(8'hCC); pb.push_back(8'hDD);
      model_stream(0, 1);

      // Random payloads, short lengths first
      for (int r = 0; r < 16; r++) begin
         len = (r < 5) ? r + 1 : $urandom_range(1, 300);
         pb.delete();
         for (int i = 0; i < len; i++) pb.push_back(8'($urandom_range(0, 255)));
         model_stream($urandom_range(0, 2), $urandom_range(0, 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
